// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: micro-op codes, bus transfer sizes, FSM states.
package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        MemOpNone = 4'd0,
        MemOpLb   = 4'd1,
        MemOpLbu  = 4'd2,
        MemOpLh   = 4'd3,
        MemOpLhu  = 4'd4,
        MemOpLw   = 4'd5,
        MemOpSb   = 4'd6,
        MemOpSh   = 4'd7,
        MemOpSw   = 4'd8
    } mem_op_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    function automatic logic op_is_load(mem_op_e op);
        return (op >= MemOpLb) && (op <= MemOpLw);
    endfunction

    function automatic logic op_is_store(mem_op_e op);
        return (op >= MemOpSb) && (op <= MemOpSw);
    endfunction

    function automatic logic [1:0] op_size(mem_op_e op);
        case (op)
            MemOpLb, MemOpLbu, MemOpSb: return SizeByte;
            MemOpLh, MemOpLhu, MemOpSh: return SizeHalf;
            default:                    return SizeWord;
        endcase
    endfunction

    function automatic logic op_misaligned(mem_op_e op, logic [1:0] addr_lo);
        case (op)
            MemOpLh, MemOpLhu, MemOpSh: return addr_lo[0];
            MemOpLw, MemOpSw:           return |addr_lo;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 4-lane data bus: store strobes/replication and load extract/extend.
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  mem_op_e           op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wstrb   = 4'b0000;
        wdata   = st_data;
        ld_data = rdata;
        case (op)
            MemOpSb: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {(DATA_W/8){st_data[7:0]}};
            end
            MemOpSh: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {(DATA_W/16){st_data[15:0]}};
            end
            MemOpSw:  wstrb   = 4'b1111;
            MemOpLb:  ld_data = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            MemOpLbu: ld_data = {{(DATA_W-8){1'b0}}, rd_byte};
            MemOpLh:  ld_data = {{(DATA_W-16){rd_half[15]}}, rd_half};
            MemOpLhu: ld_data = {{(DATA_W-16){1'b0}}, rd_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage and MEM/WB register: drives the req/addr_ok/data_ok data bus.
// Optional misalignment trapping (adel_o/ades_o) is built with MEM_ALIGN_CHECK_EN defined.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [3:0]         mem_op_i,
    input  logic [DATA_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic               we_o,
    output logic [RADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic               data_req,
    output logic               data_wr,
    output logic [1:0]         data_size,
    output logic [DATA_W-1:0]  data_addr,
    output logic [3:0]         data_wstrb,
    output logic [DATA_W-1:0]  data_wdata,
    input  logic               data_addr_ok,
    input  logic               data_data_ok,
    input  logic [DATA_W-1:0]  data_rdata,
    output logic               adel_o,
    output logic               ades_o
);

    state_e             state_q;
    mem_op_e            op_in, op_q, lane_op;
    logic [RADDR_W-1:0] waddr_q;
    logic               is_load_in, is_store_in, is_mem_in;
    logic               misalign, start, complete;
    logic [1:0]         lane_addr;
    logic [3:0]         lane_wstrb;
    logic [DATA_W-1:0]  lane_wdata, lane_ld;

    assign op_in       = mem_op_e'(mem_op_i);
    assign is_load_in  = op_is_load(op_in);
    assign is_store_in = op_is_store(op_in);
    assign is_mem_in   = is_load_in || is_store_in;

    assign start    = (state_q == StIdle) && valid_i && is_mem_in && !misalign;
    assign complete = ((state_q == StReq) && data_addr_ok && data_data_ok) ||
                      ((state_q == StWait) && data_data_ok);
    // Released in the completion cycle so EX/MEM advances on the same edge as write-back.
    assign stall_o  = start || ((state_q != StIdle) && !complete);

    // Store lanes are formed from the live inputs at issue; load lanes from the latched op.
    assign lane_op   = (state_q == StIdle) ? op_in : op_q;
    assign lane_addr = (state_q == StIdle) ? mem_addr_i[1:0] : data_addr[1:0];

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .op      (lane_op),
        .addr_lo (lane_addr),
        .st_data (mem_wdata_i),
        .rdata   (data_rdata),
        .wstrb   (lane_wstrb),
        .wdata   (lane_wdata),
        .ld_data (lane_ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            op_q       <= MemOpNone;
            waddr_q    <= '0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wstrb <= 4'b0000;
            data_wdata <= '0;
            valid_o    <= 1'b0;
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StReq;
                        op_q       <= op_in;
                        waddr_q    <= waddr_i;
                        data_req   <= 1'b1;
                        data_wr    <= is_store_in;
                        data_size  <= op_size(op_in);
                        data_addr  <= mem_addr_i;
                        data_wstrb <= is_store_in ? lane_wstrb : 4'b0000;
                        data_wdata <= is_store_in ? lane_wdata : '0;
                        valid_o    <= 1'b0;
                        we_o       <= 1'b0;
                    end else if (valid_i && is_mem_in) begin
                        // Trapped misaligned access: one-cycle bubble without a register write.
                        valid_o <= 1'b1;
                        we_o    <= 1'b0;
                        waddr_o <= waddr_i;
                        wdata_o <= '0;
                    end else begin
                        valid_o <= valid_i;
                        we_o    <= valid_i && we_i;
                        waddr_o <= waddr_i;
                        wdata_o <= wdata_i;
                    end
                end
                StReq: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state_q  <= data_data_ok ? StIdle : StWait;
                    end
                end
                StWait: begin
                    if (data_data_ok) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (state_q != StIdle) begin
                valid_o <= complete;
                we_o    <= complete && op_is_load(op_q);
                if (complete) begin
                    waddr_o <= waddr_q;
                    wdata_o <= op_is_load(op_q) ? lane_ld : '0;
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic adel_q, ades_q;

    assign misalign = op_misaligned(op_in, mem_addr_i[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
        end else begin
            adel_q <= (state_q == StIdle) && valid_i && misalign && is_load_in;
            ades_q <= (state_q == StIdle) && valid_i && misalign && is_store_in;
        end
    end

    assign adel_o = adel_q;
    assign ades_o = ades_q;
`else
    assign misalign = 1'b0;
    assign adel_o   = 1'b0;
    assign ades_o   = 1'b0;
`endif

endmodule
